// File: rtl/sync_fifo.sv
// sync_fifo: single-clock, first-word-fall-through FIFO.
// The head word is presented combinationally on read_data whenever the FIFO
// is non-empty. Registered empty/full flags are provided, together with the
// combinational values those flags will take at the next rising edge.
//
// Handshake semantics:
//   push side: a word is taken on a rising edge when write_en=1 and the
//              registered fifo_full=0 (fifo_full acts as the inverse of ready).
//   pop side:  read_data is valid whenever the registered fifo_empty=0; the
//              head is consumed on a rising edge when read_en=1 and
//              fifo_empty=0. Requests made while not ready are dropped.
//
// FIFO_DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally at their bit width.
module sync_fifo #(
  parameter int BIT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_en,
  output logic [BIT_WIDTH-1:0] read_data,
  input  logic                 write_en,
  input  logic [BIT_WIDTH-1:0] write_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 fifo_empty_next,
  output logic                 fifo_full_next
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 do_write;
  logic                 do_read;
  logic                 empty_raw;
  logic                 full_raw;

  // Accept decisions use only the registered flags of the current cycle, so a
  // push into a full FIFO is dropped even when a pop happens on the same edge.
  assign do_write = write_en & ~fifo_full;
  assign do_read  = read_en & ~fifo_empty;

  // Zero-latency head-of-queue view; stale or zero when the FIFO is empty.
  assign read_data = mem[rd_ptr];

  // Occupancy after the coming edge: +1 on push only, -1 on pop only.
  always_comb begin
    count_next = count;
    unique case ({do_write, do_read})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign empty_raw = (count_next == '0);
  assign full_raw  = (count_next == DEPTH_C);

  // While reset is held the look-ahead flags report the reset state.
  assign fifo_empty_next = ~rst | empty_raw;
  assign fifo_full_next  = rst & full_raw;

  // Pointers, occupancy and registered flags; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      fifo_empty <= empty_raw;
      fifo_full  <= full_raw;
    end
  end

  // Storage array; cleared on reset so read_data shows zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[wr_ptr] <= write_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven directed vectors, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W = 16;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         read_en;
  logic [W-1:0] read_data;
  logic         write_en;
  logic [W-1:0] write_data;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_empty_next;
  logic         fifo_full_next;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo #(.BIT_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_en         (read_en),
    .read_data       (read_data),
    .write_en        (write_en),
    .write_data      (write_data),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_empty_next (fifo_empty_next),
    .fifo_full_next  (fifo_full_next)
  );

  // ---------------- scoreboard ----------------
  int           n_vec;
  int           n_err;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         we;
    logic         re;
    logic [W-1:0] wd;
    logic         e;
    logic         f;
    logic         en;
    logic         fn;
    logic [W-1:0] rd;
  } vec_t;

  vec_t vecs[16];

  task automatic set_vec(input int i, input logic we, input logic re, input logic [W-1:0] wd,
                         input logic e, input logic f, input logic en, input logic fn,
                         input logic [W-1:0] rd);
    vecs[i].we = we; vecs[i].re = re; vecs[i].wd = wd;
    vecs[i].e  = e;  vecs[i].f  = f;  vecs[i].en = en; vecs[i].fn = fn;
    vecs[i].rd = rd;
  endtask

  // ---------------- driver tasks ----------------
  // One model-checked cycle: drive at negedge, compare pre-edge outputs,
  // then advance the reference queue according to the accept rules.
  task automatic step(input logic we, input logic re, input logic [W-1:0] wd, input string tag);
    int  n;
    int  nn;
    bit  acc_w;
    bit  acc_r;
    @(negedge clk);
    write_en   = we;
    read_en    = re;
    write_data = wd;
    #1;
    n     = exp_q.size();
    acc_w = we && (n != D);
    acc_r = re && (n != 0);
    nn    = n + int'(acc_w) - int'(acc_r);
    check({tag, "_empty"},      32'(fifo_empty),      32'(n == 0));
    check({tag, "_full"},       32'(fifo_full),       32'(n == D));
    check({tag, "_empty_next"}, 32'(fifo_empty_next), 32'(nn == 0));
    check({tag, "_full_next"},  32'(fifo_full_next),  32'(nn == D));
    if (n != 0) check({tag, "_rdata"}, 32'(read_data), 32'(exp_q[0]));
    @(posedge clk);
    if (acc_r) void'(exp_q.pop_front());
    if (acc_w) exp_q.push_back(wd);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_empty"},      32'(fifo_empty),      32'd1);
    check({tag, "_full"},       32'(fifo_full),       32'd0);
    check({tag, "_empty_next"}, 32'(fifo_empty_next), 32'd1);
    check({tag, "_full_next"},  32'(fifo_full_next),  32'd0);
    check({tag, "_rdata"},      32'(read_data),       32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = '0;

    //          we    re    wd      e  f  en fn rd
    set_vec(0,  1'b0, 1'b0, 16'h0, 1, 0, 1, 0, 16'h0000);  // idle after reset
    set_vec(1,  1'b1, 1'b0, 16'h1, 1, 0, 0, 0, 16'h0000);  // push 1
    set_vec(2,  1'b1, 1'b0, 16'h2, 0, 0, 0, 0, 16'h0001);  // push 2
    set_vec(3,  1'b1, 1'b0, 16'h3, 0, 0, 0, 0, 16'h0001);  // push 3
    set_vec(4,  1'b1, 1'b0, 16'h4, 0, 0, 0, 1, 16'h0001);  // push 4 -> full_next
    set_vec(5,  1'b1, 1'b0, 16'h5, 0, 1, 0, 1, 16'h0001);  // push while full ignored
    set_vec(6,  1'b0, 1'b1, 16'h0, 0, 1, 0, 0, 16'h0001);  // pop 1
    set_vec(7,  1'b0, 1'b1, 16'h0, 0, 0, 0, 0, 16'h0002);  // pop 2
    set_vec(8,  1'b0, 1'b1, 16'h0, 0, 0, 0, 0, 16'h0003);  // pop 3
    set_vec(9,  1'b0, 1'b1, 16'h0, 0, 0, 1, 0, 16'h0004);  // pop 4 -> empty_next
    set_vec(10, 1'b0, 1'b1, 16'h0, 1, 0, 1, 0, 16'h0001);  // pop while empty ignored, stale word
    set_vec(11, 1'b0, 1'b0, 16'h0, 1, 0, 1, 0, 16'h0001);  // idle, unchanged
    set_vec(12, 1'b1, 1'b1, 16'hAA, 1, 0, 0, 0, 16'h0001); // push+pop on empty
    set_vec(13, 1'b0, 1'b0, 16'h0, 0, 0, 0, 0, 16'h00AA);  // AA now visible
    set_vec(14, 1'b0, 1'b1, 16'h0, 0, 0, 1, 0, 16'h00AA);  // pop AA
    set_vec(15, 1'b0, 1'b0, 16'h0, 1, 0, 1, 0, 16'h0002);  // empty, stale mem[1]

    // Reset held across edges, then released on a falling edge.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_empty",      32'(fifo_empty),      32'd1);
    check("reset_hold_empty_next", 32'(fifo_empty_next), 32'd1);
    check("reset_hold_rdata",      32'(read_data),       32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      write_en   = vecs[i].we;
      read_en    = vecs[i].re;
      write_data = vecs[i].wd;
      #1;
      check($sformatf("v%0d_empty", i),      32'(fifo_empty),      32'(vecs[i].e));
      check($sformatf("v%0d_full", i),       32'(fifo_full),       32'(vecs[i].f));
      check($sformatf("v%0d_empty_next", i), 32'(fifo_empty_next), 32'(vecs[i].en));
      check($sformatf("v%0d_full_next", i),  32'(fifo_full_next),  32'(vecs[i].fn));
      check($sformatf("v%0d_rdata", i),      32'(read_data),       32'(vecs[i].rd));
    end

    // Clean start for model-driven sequences.
    async_reset("rst_a");

    // Simultaneous push/pop at count=2 across pointer wrap.
    step(1'b1, 1'b0, 16'h1001, "sim_fill0");
    step(1'b1, 1'b0, 16'h1002, "sim_fill1");
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, W'(16'h2000 + i), $sformatf("sim%0d", i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, $sformatf("sim_drain%0d", i));

    // Full FIFO with push and pop together: pop taken, push dropped.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(16'h3000 + i), $sformatf("full_fill%0d", i));
    step(1'b1, 1'b1, 16'hDEAD, "full_both");
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 16'h0, $sformatf("full_drain%0d", i));

    // Reset mid-operation with two entries, then normal traffic resumes.
    step(1'b1, 1'b0, 16'h4001, "mid_fill0");
    step(1'b1, 1'b0, 16'h4002, "mid_fill1");
    async_reset("rst_mid");
    step(1'b1, 1'b0, 16'h5001, "post_push");
    step(1'b0, 1'b0, 16'h0,    "post_idle");
    step(1'b0, 1'b1, 16'h0,    "post_pop");
    step(1'b0, 1'b0, 16'h0,    "post_empty");

    // Randomized traffic: write-heavy phase, then read-heavy phase.
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic re;
      if (i < 200) begin
        we = ($urandom_range(0, 99) < 70);
        re = ($urandom_range(0, 99) < 35);
      end else begin
        we = ($urandom_range(0, 99) < 35);
        re = ($urandom_range(0, 99) < 70);
      end
      step(we, re, W'($urandom), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
